scan_receiver: RTL and testbench

Receiving end of the scanner transfer interface. Accepts a burst of scanned words from the sending scanner over a valid/ready link, holds them in a DEPTH-entry circular buffer, and drains them either on demand (rd_en) or in one flush burst. Its power FSM uses the same five power states as the sending scanner so both ends report a common state code.

---
 rtl/scan_receiver.sv | 184 ++++++++++++++++++
 tb/tb_scan_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_receiver.sv
// scan_receiver
// Receiving end of the scanner transfer link. Words arrive over a
// valid/ready handshake while in RECEIVE and are held in a DEPTH-entry
// circular buffer. They are drained on demand (rd_en) or in a single
// flush burst. The five-state power FSM uses the same state codes as
// the sending scanner.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   wake                 LOW_POWER -> STANDBY request
//   xfer_req             sender asks to start a transfer
//   xfer_valid/data/last incoming word, last word of burst marker
//   xfer_ready           word accepted this cycle (RECEIVE and not full)
//   flush                drain the whole buffer (honoured in IDLE)
//   rd_en                pop one word on demand
//   rd_valid/rd_data     registered read result, one-cycle pulse per word
//   count                occupancy 0..DEPTH
//   empty/full/almost_full  occupancy flags from the registered count
//   state                FSM state code
module scan_receiver #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 16,
   parameter int ALMOST_FULL = 13,
   parameter int IDLE_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wake,
   input  logic                       xfer_req,
   input  logic                       xfer_valid,
   input  logic [DATA_W-1:0]          xfer_data,
   input  logic                       xfer_last,
   output logic                       xfer_ready,
   input  logic                       flush,
   input  logic                       rd_en,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic [2:0]                 state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(IDLE_CYCLES + 1);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

   typedef enum logic [2:0] {
      LOW_POWER = 3'b000,
      RECEIVE   = 3'b001,
      STANDBY   = 3'b010,
      IDLE      = 3'b011,
      FLUSH     = 3'b100
   } state_t;

   state_t              state_reg;
   logic [CW-1:0]       count_reg;
   logic [CW-1:0]       count_next;
   logic [AW-1:0]       wr_ptr_reg;
   logic [AW-1:0]       rd_ptr_reg;
   logic [IW-1:0]       idle_cnt_reg;
   logic                rd_valid_reg;
   logic [DATA_W-1:0]   rd_data_reg;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                push;
   logic                pop;
   logic                is_empty;
   logic                is_full;
   logic                idle_quiet;

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == DEPTH_C);

   // Ready comes only from registers, so a pop while full does not
   // reopen the link until the following cycle.
   assign xfer_ready = (state_reg == RECEIVE) && !is_full;
   assign push       = xfer_valid && xfer_ready;

   // FLUSH pops on its own every cycle; everywhere else only rd_en pops.
   assign pop = (state_reg == FLUSH) ? !is_empty : (rd_en && !is_empty);

   // Any stored word or read attempt keeps the receiver awake.
   assign idle_quiet = is_empty && !rd_en;

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + ONE_C;
      end else if (!push && pop) begin
         count_next = count_reg - ONE_C;
      end
   end

   // Buffer storage: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= xfer_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= LOW_POWER;
         count_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         idle_cnt_reg <= '0;
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         count_reg    <= count_next;
         rd_valid_reg <= pop;
         // Counter only survives consecutive quiet cycles in IDLE.
         idle_cnt_reg <= '0;

         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            rd_data_reg <= mem[rd_ptr_reg];
         end

         case (state_reg)
            LOW_POWER: begin
               if (xfer_req) begin
                  state_reg <= RECEIVE;
               end else if (wake) begin
                  state_reg <= STANDBY;
               end
            end
            STANDBY: begin
               if (xfer_req) begin
                  state_reg <= RECEIVE;
               end
            end
            RECEIVE: begin
               if (push && xfer_last) begin
                  state_reg <= IDLE;
               end
            end
            IDLE: begin
               if (xfer_req) begin
                  state_reg <= RECEIVE;
               end else if (flush) begin
                  state_reg <= FLUSH;
               end else if (idle_quiet) begin
                  if (idle_cnt_reg == IDLE_LAST) begin
                     state_reg <= LOW_POWER;
                  end else begin
                     idle_cnt_reg <= idle_cnt_reg + 1'b1;
                  end
               end
            end
            FLUSH: begin
               // count of 1 means this edge pops the last word; 0 means
               // there was nothing to drain at all.
               if (count_reg <= ONE_C) begin
                  state_reg <= LOW_POWER;
               end
            end
            default: begin
               state_reg <= LOW_POWER;
            end
         endcase
      end
   end

   assign rd_valid    = rd_valid_reg;
   assign rd_data     = rd_data_reg;
   assign count       = count_reg;
   assign empty       = is_empty;
   assign full        = is_full;
   assign almost_full = (count_reg >= AF_C);
   assign state       = state_reg;

endmodule

// File: tb/tb_scan_receiver.sv
module tb_scan_receiver;

   logic       clk;
   logic       rst;
   logic       wake;
   logic       xfer_req;
   logic       xfer_valid;
   logic [7:0] xfer_data;
   logic       xfer_last;
   logic       xfer_ready;
   logic       flush;
   logic       rd_en;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic [2:0] state;

   int checks_cnt;
   int fail_cnt;

   scan_receiver #(
      .DATA_W(8), .DEPTH(16), .ALMOST_FULL(13), .IDLE_CYCLES(64)
   ) dut (
      .clk(clk), .rst(rst), .wake(wake), .xfer_req(xfer_req),
      .xfer_valid(xfer_valid), .xfer_data(xfer_data), .xfer_last(xfer_last),
      .xfer_ready(xfer_ready), .flush(flush), .rd_en(rd_en),
      .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
      .empty(empty), .full(full), .almost_full(almost_full), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] fexp [7];
      logic       stayed;
      fexp = '{8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h5A, 8'h5B};
      checks_cnt = 0;
      fail_cnt   = 0;
      rst = 1'b1; wake = 1'b0; xfer_req = 1'b0; xfer_valid = 1'b0;
      xfer_data = 8'h00; xfer_last = 1'b0; flush = 1'b0; rd_en = 1'b0;

      // Reset values
      tick(); tick();
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_count", 32'(count), 32'd0);
      check_val("rst_empty", 32'(empty), 32'd1);
      check_val("rst_full", 32'(full), 32'd0);
      check_val("rst_af", 32'(almost_full), 32'd0);
      check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_val("rst_rd_data", 32'(rd_data), 32'd0);
      check_val("rst_ready", 32'(xfer_ready), 32'd0);
      rst = 1'b0;

      // Power-up path: wake -> STANDBY, xfer_req -> RECEIVE
      wake = 1'b1; tick(); wake = 1'b0;
      check_val("wake_state", 32'(state), 32'd2);
      xfer_req = 1'b1; tick(); xfer_req = 1'b0;
      check_val("req_state", 32'(state), 32'd1);
      check_val("req_ready", 32'(xfer_ready), 32'd1);
      check_val("req_empty", 32'(empty), 32'd1);

      // Five-word burst ending with xfer_last
      for (int i = 0; i < 5; i++) begin
         xfer_valid = 1'b1; xfer_data = 8'(8'h11 + i); xfer_last = (i == 4);
         tick();
         check_val($sformatf("burst_count%0d", i), 32'(count), 32'(i + 1));
      end
      xfer_valid = 1'b0; xfer_last = 1'b0;
      check_val("burst_state", 32'(state), 32'd3);

      // Demand reads in IDLE
      rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val($sformatf("rd_valid%0d", i), 32'(rd_valid), 32'd1);
         check_val($sformatf("rd_data%0d", i), 32'(rd_data), 32'(8'h11 + i));
      end
      check_val("rd_empty", 32'(empty), 32'd1);
      // rd_en while empty: ignored, but it clears the idle counter
      tick(); rd_en = 1'b0;
      check_val("rd_empty_valid", 32'(rd_valid), 32'd0);
      check_val("rd_empty_count", 32'(count), 32'd0);

      // Idle timeout with a restart pulse at cycle 30
      for (int i = 0; i < 29; i++) tick();
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check_val("idle_pulse_state", 32'(state), 32'd3);
      stayed = 1'b1;
      for (int i = 0; i < 63; i++) begin
         tick();
         if (state !== 3'd3) stayed = 1'b0;
      end
      check_val("idle_hold63", 32'(stayed), 32'd1);
      tick();
      check_val("idle_timeout", 32'(state), 32'd0);

      // Word offered outside RECEIVE is dropped
      xfer_valid = 1'b1; xfer_data = 8'hEE; tick(); xfer_valid = 1'b0;
      check_val("drop_count", 32'(count), 32'd0);
      check_val("drop_ready", 32'(xfer_ready), 32'd0);

      // Fill to full with continuous valid, no last
      xfer_req = 1'b1; tick(); xfer_req = 1'b0;
      check_val("fill_state", 32'(state), 32'd1);
      xfer_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         xfer_data = 8'(8'h40 + i);
         tick();
         check_val($sformatf("fill_count%0d", i), 32'(count), 32'((i + 1 > 16) ? 16 : i + 1));
         if (i == 11) check_val("af_at12", 32'(almost_full), 32'd0);
         if (i == 12) check_val("af_at13", 32'(almost_full), 32'd1);
         if (i == 14) check_val("full_at15", 32'(full), 32'd0);
         if (i == 15) begin
            check_val("full_at16", 32'(full), 32'd1);
            check_val("ready_full", 32'(xfer_ready), 32'd0);
         end
      end
      // Pop while full: push still blocked this cycle
      xfer_data = 8'h99; rd_en = 1'b1; tick(); rd_en = 1'b0; xfer_valid = 1'b0;
      check_val("popfull_count", 32'(count), 32'd15);
      check_val("popfull_data", 32'(rd_data), 32'h40);
      check_val("popfull_ready", 32'(xfer_ready), 32'd1);
      // Simultaneous push and pop
      xfer_valid = 1'b1; xfer_data = 8'h5A; rd_en = 1'b1; tick(); rd_en = 1'b0;
      check_val("pushpop_count", 32'(count), 32'd15);
      check_val("pushpop_data", 32'(rd_data), 32'h41);
      xfer_data = 8'h5B; xfer_last = 1'b1; tick();
      xfer_valid = 1'b0; xfer_last = 1'b0;
      check_val("last_state", 32'(state), 32'd3);
      check_val("last_count", 32'(count), 32'd16);
      rd_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         check_val($sformatf("drain_data%0d", i), 32'(rd_data), 32'(8'h42 + i));
      end
      rd_en = 1'b0;
      check_val("pre_flush_count", 32'(count), 32'd7);

      // Flush 7 words across the pointer wrap
      flush = 1'b1; tick(); flush = 1'b0;
      check_val("flush_state", 32'(state), 32'd4);
      for (int i = 0; i < 7; i++) begin
         tick();
         check_val($sformatf("flush_valid%0d", i), 32'(rd_valid), 32'd1);
         check_val($sformatf("flush_data%0d", i), 32'(rd_data), 32'(fexp[i]));
      end
      check_val("flush_end_state", 32'(state), 32'd0);
      check_val("flush_end_count", 32'(count), 32'd0);
      tick();
      check_val("flush_after_valid", 32'(rd_valid), 32'd0);

      // Reset in the middle of a burst
      xfer_req = 1'b1; tick(); xfer_req = 1'b0;
      xfer_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         xfer_data = 8'(8'h60 + i);
         tick();
      end
      check_val("midburst_count", 32'(count), 32'd9);
      rst = 1'b1; tick(); rst = 1'b0; xfer_valid = 1'b0;
      check_val("midrst_state", 32'(state), 32'd0);
      check_val("midrst_count", 32'(count), 32'd0);
      check_val("midrst_ready", 32'(xfer_ready), 32'd0);
      check_val("midrst_empty", 32'(empty), 32'd1);

      // New transfer after reset; flush is ignored in RECEIVE
      xfer_req = 1'b1; tick(); xfer_req = 1'b0;
      xfer_valid = 1'b1; xfer_data = 8'hA1; flush = 1'b1; tick(); flush = 1'b0;
      check_val("rx_flush_ign", 32'(state), 32'd1);
      check_val("rx_count1", 32'(count), 32'd1);
      xfer_data = 8'hA2; xfer_last = 1'b1; tick();
      xfer_valid = 1'b0; xfer_last = 1'b0;
      check_val("rx2_state", 32'(state), 32'd3);
      rd_en = 1'b1;
      tick();
      check_val("post_rst_data0", 32'(rd_data), 32'hA1);
      tick(); rd_en = 1'b0;
      check_val("post_rst_data1", 32'(rd_data), 32'hA2);
      check_val("post_rst_empty", 32'(empty), 32'd1);

      // Flush of an empty buffer: straight back to LOW_POWER, no pop
      flush = 1'b1; tick(); flush = 1'b0;
      check_val("eflush_state", 32'(state), 32'd4);
      tick();
      check_val("eflush_end", 32'(state), 32'd0);
      check_val("eflush_valid", 32'(rd_valid), 32'd0);
      check_val("eflush_count", 32'(count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
